// File: rtl/name_scroll_seq_if.sv
// Control and display bundle for name_scroll_seq.
// The master drives the controls and the slave (the sequencer) drives the display and status.
interface name_scroll_seq_if;
    logic       ena;
    logic       run;
    logic       step;
    logic [1:0] speed;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] char_idx;
    logic       showing;

    modport master (
        output ena, run, step, speed,
        input  seg, dp, char_idx, showing
    );

    modport slave (
        input  ena, run, step, speed,
        output seg, dp, char_idx, showing
    );
endinterface

// File: rtl/name_scroll_seq.sv
// Steps "QPG" one glyph at a time onto a 7-segment display, with blank gaps and an end pause.
// Optional macro DP_HEARTBEAT_EN: dp toggles on every advance while the sequence is running.
module name_scroll_seq #(
    parameter int unsigned TICK_DIV  = 16,
    parameter int unsigned NAME_LEN  = 3,
    parameter int unsigned END_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    name_scroll_seq_if.slave  bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned EW = (END_TICKS > 1) ? $clog2(END_TICKS) : 1;
    localparam logic [PW:0] DIV = (PW+1)'(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_END
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [PW:0]   w_lim_m1;
    logic          w_run_en;
    logic          w_tick;
    logic          w_step_edge;
    logic          w_adv;
    logic          r_step_q;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [EW-1:0] r_end_cnt;
    logic [EW-1:0] w_end_cnt_nxt;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg_nxt;
    logic          r_showing;
    logic          w_showing_nxt;

    function automatic logic [6:0] glyph(input logic [2:0] i);
        case (i)
            3'd0:    glyph = 7'h67;
            3'd1:    glyph = 7'h73;
            3'd2:    glyph = 7'h3D;
            default: glyph = 7'h00;
        endcase
    endfunction

    // A speed drop below the current count lets the counter run on and wrap at full width.
    always_comb begin
        w_run_en    = bus.ena & bus.run;
        w_lim_m1    = (DIV >> bus.speed) - (PW+1)'(1);
        w_tick      = w_run_en && (r_presc == w_lim_m1[PW-1:0]);
        w_step_edge = bus.ena & ~bus.run & bus.step & ~r_step_q;
        w_adv       = w_tick | w_step_edge;
        if (!w_run_en || w_tick) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + PW'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_end_cnt_nxt = r_end_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_run_en || w_step_edge) begin
                    w_state_nxt = S_SHOW;
                    w_idx_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (w_adv) begin
                    if (r_idx < 3'(NAME_LEN - 1)) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt   = S_END;
                        w_end_cnt_nxt = '0;
                    end
                end
            end
            S_GAP: begin
                if (w_adv) begin
                    w_state_nxt = S_SHOW;
                    w_idx_nxt   = r_idx + 3'd1;
                end
            end
            S_END: begin
                if (w_adv) begin
                    if (r_end_cnt == EW'(END_TICKS - 1)) begin
                        w_state_nxt = S_SHOW;
                        w_idx_nxt   = '0;
                    end else begin
                        w_end_cnt_nxt = r_end_cnt + EW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_showing_nxt = (w_state_nxt == S_SHOW);
        w_seg_nxt     = w_showing_nxt ? glyph(w_idx_nxt) : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_step_q  <= 1'b0;
            r_idx     <= '0;
            r_end_cnt <= '0;
            r_seg     <= '0;
            r_showing <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_step_q  <= bus.step;
            r_idx     <= w_idx_nxt;
            r_end_cnt <= w_end_cnt_nxt;
            r_seg     <= w_seg_nxt;
            r_showing <= w_showing_nxt;
        end
    end

`ifdef DP_HEARTBEAT_EN
    logic r_dp;

    always_ff @(posedge clk) begin
        if (!rst_n || r_state == S_IDLE) begin
            r_dp <= 1'b0;
        end else if (w_adv) begin
            r_dp <= ~r_dp;
        end
    end

    assign bus.dp = r_dp;
`else
    assign bus.dp = 1'b0;
`endif

    assign bus.seg      = r_seg;
    assign bus.char_idx = r_idx;
    assign bus.showing  = r_showing;

endmodule

// File: tb/tb_name_scroll_seq.sv
// Randomized and directed bench for name_scroll_seq against a sequence-position reference model.
module tb_name_scroll_seq;

    localparam int unsigned TICK_DIV = 16;
    localparam int unsigned FULL     = 1 << $clog2(TICK_DIV);
    localparam int unsigned SEQ_LEN  = 8;

    logic clk;
    logic rst_n;

    name_scroll_seq_if bus ();

    name_scroll_seq #(
        .TICK_DIV  (TICK_DIV),
        .NAME_LEN  (3),
        .END_TICKS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Expected display over one full cycle: Q gap P gap G end end end.
    int unsigned seq_seg [SEQ_LEN] = '{'h67, 0, 'h73, 0, 'h3D, 0, 0, 0};
    int unsigned seq_idx [SEQ_LEN] = '{0, 0, 1, 1, 2, 2, 2, 2};

    bit          m_started;
    int unsigned m_pos;
    int unsigned m_pcnt;
    bit          m_sq;
    bit          m_dp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int unsigned lim;
        bit runen, tick, sedge;
        if (!rst_n) begin
            m_started = 0;
            m_pos     = 0;
            m_pcnt    = 0;
            m_sq      = 0;
            m_dp      = 0;
        end else begin
            lim   = TICK_DIV >> bus.speed;
            runen = bus.ena && bus.run;
            tick  = runen && (m_pcnt == lim - 1);
            sedge = bus.ena && !bus.run && bus.step && !m_sq;
            if (!m_started) begin
                if (runen || sedge) begin
                    m_started = 1;
                    m_pos     = 0;
                end
            end else if (tick || sedge) begin
                m_dp  = !m_dp;
                m_pos = (m_pos + 1) % SEQ_LEN;
            end
            if (!runen || tick) m_pcnt = 0;
            else                m_pcnt = (m_pcnt + 1) % FULL;
            m_sq = bus.step;
        end
    endtask

    task automatic cyc();
        bit exp_dp;
        @(posedge clk);
        model_step();
        #1;
`ifdef DP_HEARTBEAT_EN
        exp_dp = m_started && m_dp;
`else
        exp_dp = 0;
`endif
        check_eq("seg",      32'(bus.seg),      m_started ? seq_seg[m_pos] : 0);
        check_eq("char_idx", 32'(bus.char_idx), m_started ? seq_idx[m_pos] : 0);
        check_eq("showing",  32'(bus.showing),
                 32'(m_started && (m_pos == 0 || m_pos == 2 || m_pos == 4)));
        check_eq("dp",       32'(bus.dp),       32'(exp_dp));
    endtask

    task automatic run_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit found;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.ena   = 1'b0;
        bus.run   = 1'b0;
        bus.step  = 1'b0;
        bus.speed = 2'd0;
        m_started = 0; m_pos = 0; m_pcnt = 0; m_sq = 0; m_dp = 0;

        // Reset, then idle with run low.
        run_cycles(2);
        rst_n   = 1'b1;
        bus.ena = 1'b1;
        run_cycles(4);

        // Auto-run at full period across more than one wrap.
        bus.run = 1'b1;
        run_cycles(150);

        // Fast speed, then slow down right after a tick.
        bus.speed = 2'd3;
        run_cycles(30);
        found = 0;
        for (int unsigned i = 0; i < 10 && !found; i++) begin
            cyc();
            found = (m_pcnt == 0) && m_started && (m_pos % 2 == 0) && (m_pos < 5);
        end
        check_eq("bound_speed_sync", 32'(found), 32'd1);
        bus.speed = 2'd0;
        run_cycles(40);

        // Manual: held step advances once; step coincident with a tick.
        bus.run  = 1'b0;
        bus.step = 1'b1;
        run_cycles(5);
        bus.step = 1'b0;
        run_cycles(3);
        bus.run = 1'b1;
        found = 0;
        for (int unsigned i = 0; i < 40 && !found; i++) begin
            cyc();
            found = (m_pcnt == TICK_DIV - 1);
        end
        check_eq("bound_tick_align", 32'(found), 32'd1);
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
        run_cycles(20);

        // Pause while P is shown.
        found = 0;
        for (int unsigned i = 0; i < 200 && !found; i++) begin
            cyc();
            found = m_started && (m_pos == 2);
        end
        check_eq("bound_reach_p", 32'(found), 32'd1);
        bus.ena = 1'b0;
        run_cycles(40);
        check_eq("pause_seg", 32'(bus.seg), 32'h73);
        bus.ena = 1'b1;
        run_cycles(40);

        // Reset during the end blank.
        found = 0;
        for (int unsigned i = 0; i < 200 && !found; i++) begin
            cyc();
            found = m_started && (m_pos >= 5);
        end
        check_eq("bound_reach_end", 32'(found), 32'd1);
        rst_n = 1'b0;
        cyc();
        check_eq("rst_seg", 32'(bus.seg), 32'h0);
        check_eq("rst_idx", 32'(bus.char_idx), 32'h0);
        check_eq("rst_dp",  32'(bus.dp), 32'h0);
        rst_n = 1'b1;
        run_cycles(10);

        // Randomized stimulus.
        for (int unsigned i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(199) != 0);
            bus.ena  = ($urandom_range(9) != 0);
            if ($urandom_range(29) == 0) bus.run = ~bus.run;
            bus.step = ($urandom_range(3) == 0);
            if ($urandom_range(59) == 0) bus.speed = 2'($urandom_range(3));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
